// File: rtl/reverb_param_ctrl.sv
// reverb_param_ctrl
// -----------------
// Configuration sequencer for the Schroeder reverberator datapath
// (4 comb + 2 all-pass + wet gain). The host writes six tau values and
// seven gain values into shadow registers. A commit applies the whole set
// atomically on a sample boundary. After that the gains ramp toward their
// new targets once per sample, which avoids zipper noise.
//
// Ports
//   clk         system clock
//   rstn        asynchronous active-low reset
//   sample_tick one-clk strobe per audio sample, synchronous to clk
//   wr_valid    host write request
//   wr_ready    write accepted when wr_valid && wr_ready (low only in APPLY)
//   wr_addr     0-5 = tau[0..5], 6-12 = gain[0..6], >12 = address error
//   wr_data     signed fixed-point value (WORD = WIDTH+FRAC bits)
//   commit      one-clk pulse: apply the shadow set
//   tau         per-filter delay to the datapath, signed fixed-point samples
//   gain        per-filter gain to the datapath, signed fixed-point
//   busy        high outside IDLE or while a commit is pending
//   clamp       one-clk pulse one cycle after a write that was clamped
//   addr_err    one-clk pulse one cycle after a write to an address > 12

`ifndef FIXED_POINT
`define FIXED_POINT 8
`endif
`ifndef MAX_FILTER_FIFO_LENGTH
`define MAX_FILTER_FIFO_LENGTH 4096
`endif

module reverb_param_ctrl #(
    parameter int WIDTH      = 24,
    parameter int FRAC       = `FIXED_POINT,
    parameter int MAXDELAY   = `MAX_FILTER_FIFO_LENGTH,
    parameter int RAMP_SHIFT = 4,
    localparam int WORD      = WIDTH + FRAC
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   sample_tick,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [3:0]             wr_addr,
    input  logic signed [WORD-1:0] wr_data,
    input  logic                   commit,
    output logic [0:5][WORD-1:0]   tau,
    output logic [0:6][WORD-1:0]   gain,
    output logic                   busy,
    output logic                   clamp,
    output logic                   addr_err
);

    localparam int ONE = 1 << FRAC;

    // Tau limits: 1 sample up to MAXDELAY-1 samples, as integer parts and
    // as full fixed-point words.
    localparam logic signed [WORD-1:0] TAU_INT_MIN = WORD'(1);
    localparam logic signed [WORD-1:0] TAU_INT_MAX = WORD'(MAXDELAY - 1);
    localparam logic signed [WORD-1:0] TAU_MIN     = WORD'(ONE);
    localparam logic signed [WORD-1:0] TAU_MAX     = WORD'((MAXDELAY - 1) << FRAC);

    // Gain is kept strictly inside (-1.0, +1.0) so the feedback loops stay stable.
    localparam logic signed [WORD-1:0] GAIN_MAX = WORD'(ONE - 1);
    localparam logic signed [WORD-1:0] GAIN_MIN = WORD'(-(ONE - 1));

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TICK,
        APPLY,
        RAMP
    } state_t;

    state_t state, state_d;
    logic   pending, pending_d;

    logic signed [WORD-1:0] shadow_tau  [0:5];
    logic signed [WORD-1:0] shadow_gain [0:6];
    logic signed [WORD-1:0] target_gain [0:6];

    logic                   accept;
    logic signed [WORD-1:0] wr_int;
    logic signed [WORD-1:0] wr_value;
    logic                   wr_clamped;

    logic signed [WORD:0]   diff     [0:6];
    logic signed [WORD:0]   step     [0:6];
    logic signed [WORD-1:0] ramp_val [0:6];
    logic                   all_equal;

    // Writes are blocked only while APPLY copies the shadow set, so a host
    // write and the atomic copy can never land in the same cycle.
    assign wr_ready = (state != APPLY);
    assign accept   = wr_valid && wr_ready;
    assign busy     = (state != IDLE) || pending;

    // Range-limit the incoming value according to the register it targets.
    // Tau is judged on its integer part only; the fraction is kept when in range.
    always_comb begin
        wr_int     = wr_data >>> FRAC;
        wr_value   = wr_data;
        wr_clamped = 1'b0;
        if (wr_addr <= 4'd5) begin
            if (wr_int < TAU_INT_MIN) begin
                wr_value   = TAU_MIN;
                wr_clamped = 1'b1;
            end else if (wr_int > TAU_INT_MAX) begin
                wr_value   = TAU_MAX;
                wr_clamped = 1'b1;
            end
        end else if (wr_addr <= 4'd12) begin
            if (wr_data > GAIN_MAX) begin
                wr_value   = GAIN_MAX;
                wr_clamped = 1'b1;
            end else if (wr_data < GAIN_MIN) begin
                wr_value   = GAIN_MIN;
                wr_clamped = 1'b1;
            end
        end
    end

    // Gain smoothing. The difference is formed one bit wider so that a full
    // swing between the gain limits cannot overflow. A zero step means the
    // remaining gap is below one smoothing increment, so snap to the target.
    // Adding the truncated step is exact because the result always lies
    // between the current gain and the target.
    always_comb begin
        all_equal = 1'b1;
        for (int i = 0; i < 7; i++) begin
            diff[i] = {target_gain[i][WORD-1], target_gain[i]} - {gain[i][WORD-1], gain[i]};
            step[i] = diff[i] >>> RAMP_SHIFT;
            if (step[i] == '0) begin
                ramp_val[i] = target_gain[i];
            end else begin
                ramp_val[i] = gain[i] + step[i][WORD-1:0];
            end
            if (gain[i] != target_gain[i]) begin
                all_equal = 1'b0;
            end
        end
    end

    // Next-state logic. A commit arriving while the sequencer is busy is
    // remembered in 'pending' (several collapse into one) and served when
    // the current ramp completes. Entering WAIT_TICK consumes it.
    always_comb begin
        state_d   = state;
        pending_d = pending;
        case (state)
            IDLE: begin
                if (commit || pending) begin
                    state_d = WAIT_TICK;
                end
            end
            WAIT_TICK: begin
                if (sample_tick) begin
                    state_d = APPLY;
                end
            end
            APPLY: begin
                state_d = RAMP;
            end
            RAMP: begin
                if (all_equal) begin
                    state_d = (pending || commit) ? WAIT_TICK : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (commit && (state != IDLE)) begin
            pending_d = 1'b1;
        end
        if ((state_d == WAIT_TICK) && (state != WAIT_TICK)) begin
            pending_d = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            pending <= 1'b0;
        end else begin
            state   <= state_d;
            pending <= pending_d;
        end
    end

    // Host write path into the shadow set, plus the status pulses, which
    // appear in the cycle after the accepting edge.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 6; i++) begin
                shadow_tau[i] <= TAU_MIN;
            end
            for (int i = 0; i < 7; i++) begin
                shadow_gain[i] <= '0;
            end
            clamp    <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            clamp    <= accept && wr_clamped;
            addr_err <= accept && (wr_addr > 4'd12);
            for (int i = 0; i < 6; i++) begin
                if (accept && (wr_addr == 4'(i))) begin
                    shadow_tau[i] <= wr_value;
                end
            end
            for (int i = 0; i < 7; i++) begin
                if (accept && (wr_addr == 4'(i + 6))) begin
                    shadow_gain[i] <= wr_value;
                end
            end
        end
    end

    // Datapath-facing registers. Tau steps to its new value in APPLY, while
    // gains only move on sample ticks during RAMP; otherwise both hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 6; i++) begin
                tau[i] <= TAU_MIN;
            end
            for (int i = 0; i < 7; i++) begin
                target_gain[i] <= '0;
                gain[i]        <= '0;
            end
        end else if (state == APPLY) begin
            for (int i = 0; i < 6; i++) begin
                tau[i] <= shadow_tau[i];
            end
            for (int i = 0; i < 7; i++) begin
                target_gain[i] <= shadow_gain[i];
            end
        end else if ((state == RAMP) && sample_tick) begin
            for (int i = 0; i < 7; i++) begin
                gain[i] <= ramp_val[i];
            end
        end
    end

endmodule

// File: tb/tb_reverb_param_ctrl.sv
// tb_reverb_param_ctrl
// --------------------
// Self-checking bench for reverb_param_ctrl (WIDTH=24, FRAC=8, MAXDELAY=4096,
// RAMP_SHIFT=4). A reference model of shadow/target/gain values predicts
// each ramp step. The predictions go into a queue when a tick is driven
// and are popped and compared once the DUT has updated.

module tb_reverb_param_ctrl;

    localparam int WORD = 32;

    logic                 clk;
    logic                 rstn;
    logic                 sample_tick;
    logic                 wr_valid;
    logic                 wr_ready;
    logic [3:0]           wr_addr;
    logic [WORD-1:0]      wr_data;
    logic                 commit;
    logic [0:5][WORD-1:0] tau;
    logic [0:6][WORD-1:0] gain;
    logic                 busy;
    logic                 clamp;
    logic                 addr_err;

    int n_checks;
    int n_pass;

    logic [WORD-1:0] model_shadow_tau  [0:5];
    logic [WORD-1:0] model_tau         [0:5];
    logic [WORD-1:0] model_shadow_gain [0:6];
    logic [WORD-1:0] model_target      [0:6];
    logic [WORD-1:0] model_gain        [0:6];
    logic [WORD-1:0] exp_q [$];

    reverb_param_ctrl #(
        .WIDTH     (24),
        .FRAC      (8),
        .MAXDELAY  (4096),
        .RAMP_SHIFT(4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sample_tick(sample_tick),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .commit     (commit),
        .tau        (tau),
        .gain       (gain),
        .busy       (busy),
        .clamp      (clamp),
        .addr_err   (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference smoothing step: move by floor(diff/16), snap when that is zero.
    function automatic logic [WORD-1:0] ramp_next(input logic [WORD-1:0] g, input logic [WORD-1:0] t);
        longint gi = longint'($signed(g));
        longint ti = longint'($signed(t));
        longint d  = ti - gi;
        longint s  = d >>> 4;
        if (s == 0) return t;
        return WORD'(gi + s);
    endfunction

    function automatic bit model_settled();
        for (int i = 0; i < 7; i++) begin
            if (model_gain[i] != model_target[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) begin
            model_shadow_tau[i] = 32'h100;
            model_tau[i]        = 32'h100;
        end
        for (int i = 0; i < 7; i++) begin
            model_shadow_gain[i] = '0;
            model_target[i]      = '0;
            model_gain[i]        = '0;
        end
        exp_q.delete();
    endtask

    task automatic model_apply();
        for (int i = 0; i < 6; i++) model_tau[i] = model_shadow_tau[i];
        for (int i = 0; i < 7; i++) model_target[i] = model_shadow_gain[i];
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [3:0] a, input logic [WORD-1:0] d,
                            output logic c, output logic e);
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        cyc();
        wr_valid = 1'b0;
        c = clamp;
        e = addr_err;
    endtask

    task automatic do_commit();
        commit = 1'b1;
        cyc();
        commit = 1'b0;
    endtask

    task automatic do_tick();
        sample_tick = 1'b1;
        cyc();
        sample_tick = 1'b0;
    endtask

    // Predict the next gain of every channel, queue the predictions, then tick.
    task automatic ramp_step();
        for (int i = 0; i < 7; i++) begin
            model_gain[i] = ramp_next(model_gain[i], model_target[i]);
            exp_q.push_back(model_gain[i]);
        end
        do_tick();
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        #2 rstn = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 6; i++) begin
                n_checks++;
                if (tau[i] !== 32'h100) $display("[TB] FAIL reset_tau%0d: got %h expected %h", i, tau[i], 32'h100);
                else n_pass++;
            end
            for (int i = 0; i < 7; i++) begin
                n_checks++;
                if (gain[i] !== 32'h0) $display("[TB] FAIL reset_gain%0d: got %h expected %h", i, gain[i], 32'h0);
                else n_pass++;
            end
            n_checks++;
            if ({busy, wr_ready, clamp, addr_err} !== 4'b0100)
                $display("[TB] FAIL reset_flags: got busy/ready/clamp/err=%b expected 0100", {busy, wr_ready, clamp, addr_err});
            else n_pass++;
            for (int t = 0; t < 3; t++) do_tick();
        end
        rstn = 1'b1;
        cyc();
    endtask

    task automatic test_gain_ramp();
        logic c, e;
        bit done = 1'b0;
        do_write(4'd6, 32'h0B3, c, e);
        model_shadow_gain[0] = 32'h0B3;
        n_checks++;
        if (c !== 1'b0) $display("[TB] FAIL ramp_noclamp: got %b expected 0", c);
        else n_pass++;
        do_commit();
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL ramp_busy_commit: got %b expected 1", busy);
        else n_pass++;
        do_tick();
        model_apply();
        n_checks++;
        if (wr_ready !== 1'b0) $display("[TB] FAIL ramp_apply_ready: got %b expected 0", wr_ready);
        else n_pass++;
        cyc();
        n_checks++;
        if (wr_ready !== 1'b1) $display("[TB] FAIL ramp_ready_after: got %b expected 1", wr_ready);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tau[i] !== 32'h100) $display("[TB] FAIL ramp_tau%0d: got %h expected %h", i, tau[i], 32'h100);
            else n_pass++;
        end
        for (int s = 0; s < 64 && !done; s++) begin
            ramp_step();
            for (int j = 0; j < 7; j++) begin
                logic [WORD-1:0] x = exp_q.pop_front();
                n_checks++;
                if (gain[j] !== x) $display("[TB] FAIL ramp_gain%0d: got %h expected %h", j, gain[j], x);
                else n_pass++;
            end
            if (s == 0) begin
                n_checks++;
                if (gain[0] !== 32'h0B) $display("[TB] FAIL ramp_first_step: got %h expected %h", gain[0], 32'h0B);
                else n_pass++;
            end
            if (s == 1) begin
                n_checks++;
                if (gain[0] !== 32'h15) $display("[TB] FAIL ramp_second_step: got %h expected %h", gain[0], 32'h15);
                else n_pass++;
            end
            done = model_settled();
            if (!done) cyc();
        end
        n_checks++;
        if (!done) $display("[TB] FAIL ramp_timeout: got unsettled expected settled within 64 ticks");
        else n_pass++;
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL ramp_busy_final: got %b expected 1", busy);
        else n_pass++;
        cyc();
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL ramp_busy_idle: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_tau_clamp();
        logic c, e;
        do_write(4'd0, 32'(4100 << 8), c, e);
        model_shadow_tau[0] = 32'(4095 << 8);
        n_checks++;
        if (c !== 1'b1) $display("[TB] FAIL tau_clamp_high: got %b expected 1", c);
        else n_pass++;
        do_write(4'd1, 32'h0, c, e);
        model_shadow_tau[1] = 32'h100;
        n_checks++;
        if (c !== 1'b1) $display("[TB] FAIL tau_clamp_low: got %b expected 1", c);
        else n_pass++;
        do_write(4'd2, 32'h1280, c, e);
        model_shadow_tau[2] = 32'h1280;
        n_checks++;
        if (c !== 1'b0) $display("[TB] FAIL tau_noclamp: got %b expected 0", c);
        else n_pass++;
        cyc();
        n_checks++;
        if (clamp !== 1'b0) $display("[TB] FAIL tau_clamp_pulse_end: got %b expected 0", clamp);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tau[i] !== 32'h100) $display("[TB] FAIL tau_before_commit%0d: got %h expected %h", i, tau[i], 32'h100);
            else n_pass++;
        end
        do_commit();
        do_tick();
        model_apply();
        cyc();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tau[i] !== model_tau[i]) $display("[TB] FAIL tau_applied%0d: got %h expected %h", i, tau[i], model_tau[i]);
            else n_pass++;
        end
        cyc();
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL tau_busy_idle: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_gain_clamp();
        logic c, e;
        bit done = 1'b0;
        do_write(4'd7, 32'h180, c, e);
        model_shadow_gain[1] = 32'h0FF;
        n_checks++;
        if (c !== 1'b1) $display("[TB] FAIL gain_clamp_pos: got %b expected 1", c);
        else n_pass++;
        do_write(4'd8, -32'sh200, c, e);
        model_shadow_gain[2] = -32'sh0FF;
        n_checks++;
        if (c !== 1'b1) $display("[TB] FAIL gain_clamp_neg: got %b expected 1", c);
        else n_pass++;
        do_write(4'd13, 32'h055, c, e);
        n_checks++;
        if ({e, c} !== 2'b10) $display("[TB] FAIL addr_err_pulse: got err/clamp=%b expected 10", {e, c});
        else n_pass++;
        cyc();
        n_checks++;
        if (addr_err !== 1'b0) $display("[TB] FAIL addr_err_end: got %b expected 0", addr_err);
        else n_pass++;
        do_commit();
        do_tick();
        model_apply();
        cyc();
        for (int s = 0; s < 200 && !done; s++) begin
            ramp_step();
            for (int j = 0; j < 7; j++) begin
                logic [WORD-1:0] x = exp_q.pop_front();
                n_checks++;
                if (gain[j] !== x) $display("[TB] FAIL gclamp_gain%0d: got %h expected %h", j, gain[j], x);
                else n_pass++;
            end
            done = model_settled();
            cyc();
        end
        n_checks++;
        if (!done) $display("[TB] FAIL gclamp_timeout: got unsettled expected settled within 200 ticks");
        else n_pass++;
        n_checks++;
        if ({gain[1], gain[2]} !== {32'h0FF, 32'hFFFFFF01})
            $display("[TB] FAIL gclamp_final: got %h %h expected 000000ff ffffff01", gain[1], gain[2]);
        else n_pass++;
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tau[i] !== model_tau[i]) $display("[TB] FAIL gclamp_tau%0d: got %h expected %h", i, tau[i], model_tau[i]);
            else n_pass++;
        end
        n_checks++;
        if (busy !== 1'b0) $display("[TB] FAIL gclamp_busy: got %b expected 0", busy);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic c, e;
        bit done = 1'b0;
        do_write(4'd6, 32'h0F0, c, e);
        model_shadow_gain[0] = 32'h0F0;
        do_commit();
        do_tick();
        model_apply();
        n_checks++;
        if (wr_ready !== 1'b0) $display("[TB] FAIL b2b_apply1_ready: got %b expected 0", wr_ready);
        else n_pass++;
        cyc();
        n_checks++;
        if (wr_ready !== 1'b1) $display("[TB] FAIL b2b_apply1_ready_after: got %b expected 1", wr_ready);
        else n_pass++;
        for (int s = 0; s < 2; s++) begin
            ramp_step();
            for (int j = 0; j < 7; j++) begin
                logic [WORD-1:0] x = exp_q.pop_front();
                n_checks++;
                if (gain[j] !== x) $display("[TB] FAIL b2b_up_gain%0d: got %h expected %h", j, gain[j], x);
                else n_pass++;
            end
        end
        do_write(4'd6, 32'h0, c, e);
        model_shadow_gain[0] = 32'h0;
        do_commit();
        do_commit();
        n_checks++;
        if (busy !== 1'b1) $display("[TB] FAIL b2b_busy_pending: got %b expected 1", busy);
        else n_pass++;
        for (int s = 0; s < 64 && !done; s++) begin
            ramp_step();
            for (int j = 0; j < 7; j++) begin
                logic [WORD-1:0] x = exp_q.pop_front();
                n_checks++;
                if (gain[j] !== x) $display("[TB] FAIL b2b_up_gain%0d: got %h expected %h", j, gain[j], x);
                else n_pass++;
            end
            done = model_settled();
            cyc();
        end
        n_checks++;
        if (!done || gain[0] !== 32'h0F0) $display("[TB] FAIL b2b_up_final: got %h expected %h", gain[0], 32'h0F0);
        else n_pass++;
        cyc();
        n_checks++;
        if ({busy, wr_ready, gain[0]} !== {1'b1, 1'b1, 32'h0F0})
            $display("[TB] FAIL b2b_waiting: got busy/ready/gain0=%b/%b/%h expected 1/1/000000f0", busy, wr_ready, gain[0]);
        else n_pass++;
        do_tick();
        model_apply();
        n_checks++;
        if (wr_ready !== 1'b0) $display("[TB] FAIL b2b_apply2_ready: got %b expected 0", wr_ready);
        else n_pass++;
        cyc();
        n_checks++;
        if (wr_ready !== 1'b1) $display("[TB] FAIL b2b_apply2_ready_after: got %b expected 1", wr_ready);
        else n_pass++;
        done = 1'b0;
        for (int s = 0; s < 200 && !done; s++) begin
            ramp_step();
            for (int j = 0; j < 7; j++) begin
                logic [WORD-1:0] x = exp_q.pop_front();
                n_checks++;
                if (gain[j] !== x) $display("[TB] FAIL b2b_down_gain%0d: got %h expected %h", j, gain[j], x);
                else n_pass++;
            end
            done = model_settled();
            cyc();
        end
        n_checks++;
        if (!done || busy !== 1'b0 || gain[0] !== 32'h0)
            $display("[TB] FAIL b2b_down_final: got busy/gain0=%b/%h expected 0/00000000", busy, gain[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid_ramp();
        logic c, e;
        do_write(4'd6, 32'h080, c, e);
        model_shadow_gain[0] = 32'h080;
        do_commit();
        do_tick();
        model_apply();
        cyc();
        ramp_step();
        for (int j = 0; j < 7; j++) begin
            logic [WORD-1:0] x = exp_q.pop_front();
            n_checks++;
            if (gain[j] !== x) $display("[TB] FAIL rmid_gain%0d: got %h expected %h", j, gain[j], x);
            else n_pass++;
        end
        do_commit();
        #2 rstn = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (tau[i] !== model_tau[i]) $display("[TB] FAIL rmid_tau%0d: got %h expected %h", i, tau[i], model_tau[i]);
            else n_pass++;
        end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (gain[i] !== 32'h0) $display("[TB] FAIL rmid_gain_reset%0d: got %h expected 0", i, gain[i]);
            else n_pass++;
        end
        n_checks++;
        if ({busy, wr_ready} !== 2'b01) $display("[TB] FAIL rmid_flags: got busy/ready=%b expected 01", {busy, wr_ready});
        else n_pass++;
        #2 rstn = 1'b1;
        do_tick();
        cyc();
        do_tick();
        cyc();
        n_checks++;
        if ({busy, gain[0], tau[0]} !== {1'b0, 32'h0, 32'h100})
            $display("[TB] FAIL rmid_after_tick: got busy/gain0/tau0=%b/%h/%h expected 0/00000000/00000100", busy, gain[0], tau[0]);
        else n_pass++;
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        sample_tick = 1'b0;
        wr_valid    = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        commit      = 1'b0;
        test_reset();
        test_gain_ramp();
        test_tau_clamp();
        test_gain_clamp();
        test_back_to_back();
        test_reset_mid_ramp();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/reverb_param_ctrl.md
Name: reverb_param_ctrl

Overview:
Configuration sequencer for the Schroeder reverberator datapath (4 comb + 2 all-pass + wet gain). Host writes the 6 tau and 7 gain values into shadow registers. A commit applies them atomically on a sample boundary, then ramps the gains toward their targets once per sample to avoid zipper noise. Sits between the register/SPI bus decoder and the reverberator core's tau/gain inputs.

Parameters:
WIDTH, 24, integer bits of a word
FRAC, `FIXED_POINT, fractional bits; WORD = WIDTH+FRAC
MAXDELAY, `MAX_FILTER_FIFO_LENGTH, FIFO depth in samples; max legal tau = MAXDELAY-1 samples
RAMP_SHIFT, 4, gain smoothing step = diff >>> RAMP_SHIFT

Ports:
clk  in  1  system clock
rstn  in  1  asynchronous active-low reset
sample_tick  in  1  one-clk strobe per audio sample, synchronous to clk
wr_valid  in  1  host write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_addr  in  4  0-5 = tau[0..5], 6-12 = gain[0..6]
wr_data  in  WORD  signed fixed-point value
commit  in  1  one-clk pulse: apply shadow set
tau  out  [0:5][WORD]  tau to datapath, signed, fixed-point samples
gain  out  [0:6][WORD]  gain to datapath, signed fixed-point
busy  out  1  high in any state except IDLE, or while a commit is pending
clamp  out  1  one-clk pulse: written value was clamped
addr_err  out  1  one-clk pulse: wr_addr > 12

Behaviour:
- Reset (async, rstn=0): shadow/target/output tau = 1<<FRAC (1 sample); shadow/target/output gain = 0; state IDLE; pending=0; busy=0; clamp=0; addr_err=0; wr_ready=1.
- Write (on accept):
  - tau: integer part (wr_data>>>FRAC) < 1 -> stored 1<<FRAC, clamp pulse.
  - tau: integer part > MAXDELAY-1 -> stored (MAXDELAY-1)<<FRAC, clamp pulse.
  - tau: otherwise stored as-is, fraction kept.
  - gain: clamped to [-(ONE-1), ONE-1], ONE = 1<<FRAC; clamp pulse if clamped.
  - addr > 12: accepted, addr_err pulse the next cycle, no register change.
  - clamp/addr_err are registered: they pulse 1 cycle after accept.
- wr_ready = 0 only in APPLY; otherwise 1.
- FSM states:
  - IDLE: commit -> WAIT_TICK.
  - WAIT_TICK: sample_tick -> APPLY.
  - APPLY (1 clk): target <= shadow (all 13); tau outputs <= shadow tau (step change); -> RAMP.
  - RAMP: on each sample_tick, update every gain i (rule below). Once all gain[i]==target[i] (checked on registered values): pending -> WAIT_TICK, else IDLE.
- Gain ramp update:
  - diff = target-gain, computed at WORD+1 bits; step = diff >>> RAMP_SHIFT.
  - step==0 -> gain <= target; else gain <= gain+step.
  - Monotone, never overshoots.
- Commit outside IDLE sets pending=1 (multiple commits collapse to one). pending is cleared on entering WAIT_TICK.
- Shadow writes in WAIT_TICK/RAMP are legal. They take effect at the next APPLY.
- Same-cycle write accept and APPLY cannot collide (wr_ready=0 in APPLY).
- sample_tick and commit in the same IDLE cycle: go to WAIT_TICK; wait for the next tick.
- Outputs change only in APPLY (tau) and on sample_tick in RAMP (gain). They are held stable otherwise.
- Reset mid-ramp: all values return to reset defaults immediately; no pending commit survives.
- Latency: commit -> tau update = first later sample_tick + 1 clk.

Test Plan:
- Reset (bench FRAC=8, RAMP_SHIFT=4, MAXDELAY=4096): assert rstn=0 -> tau all 0x100, gain all 0, busy=0, wr_ready=1; hold across 3 sample_ticks with no change.
- Write addr 6 = 0x0B3 (0.7), commit, tick:
  - gain[0] sequence per tick 0x00 -> 0x0B -> 0x15 -> ...; snaps to 0x0B3 once diff<16.
  - tau unchanged; busy falls after the final equal-check.
- Tau clamp:
  - addr 0 = (4100<<8) -> clamp pulse; after commit, tau[0] = 4095<<8.
  - addr 1 = 0 -> tau[1] = 0x100, clamp pulse.
  - addr 2 = 0x1280 -> tau[2] = 0x1280, no clamp.
- Gain clamp / address error:
  - addr 7 = 0x180 -> 0x0FF, clamp pulse.
  - addr 8 = -0x200 -> -0x0FF, clamp pulse.
  - addr 13 -> addr_err pulse, no register change.
- Commit during RAMP:
  - Write new gain[0] = 0, commit mid-ramp -> pending, busy held.
  - After first ramp completes -> WAIT_TICK, APPLY, ramp back down to 0.
  - wr_ready low exactly 1 clk in each APPLY.
- Async reset mid-ramp: rstn pulse between ticks -> outputs immediately return to defaults, state IDLE, and a later tick causes no change.
